// File: rtl/queue_arbiter.sv
// ---------------------------------------------------------------------------
// queue_arbiter
//   Collects words from several upstream fifo_queue instances into a single
//   registered output stream. One port at a time owns the output and may
//   deliver up to MAX_BURST consecutive words before the grant rotates
//   round-robin to the next nonempty port.
//
// Parameters
//   WIDTH      data word width in bits
//   PORTS      number of upstream queues (2..16)
//   MAX_BURST  words taken from one port per grant (1..255)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   q_dout     head word of each upstream queue (unpacked array)
//   q_nempty   per-port queue-not-empty flag
//   q_se       per-port pop strobe, combinational, at most one bit high
//   o_data     registered output word
//   o_src      index of the port that supplied o_data
//   o_valid    o_data/o_src hold a word
//   o_ready    downstream accepts the word when o_valid && o_ready
// ---------------------------------------------------------------------------
module queue_arbiter #(
  parameter int WIDTH     = 32,
  parameter int PORTS     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         q_dout [PORTS],
  input  logic [PORTS-1:0]         q_nempty,
  output logic [PORTS-1:0]         q_se,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(PORTS)-1:0] o_src,
  output logic                     o_valid,
  input  logic                     o_ready
);

  localparam int IW = $clog2(PORTS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [IW-1:0]    owner_q,    owner_d;
  logic [IW-1:0]    ptr_q,      ptr_d;
  logic [7:0]       burstCnt_q, burstCnt_d;
  logic [WIDTH-1:0] oData_q,    oData_d;
  logic [IW-1:0]    oSrc_q,     oSrc_d;
  logic             oValid_q,   oValid_d;

  logic             slotFree;
  logic             ownerNempty;
  logic             load;
  logic             burstDone;
  logic             rotate;
  logic [PORTS-1:0] ownerOneHot;
  logic [IW-1:0]    ownerPlus1;

  logic [IW-1:0]    srchStart;
  logic [PORTS-1:0] srchMask;
  logic [IW-1:0]    candIdx;
  logic             srchFound;
  logic [IW-1:0]    srchIdx;

  // The output register can take a new word when it is empty or when its
  // current word is being accepted on this same edge.
  always_comb begin
    slotFree    = !oValid_q || o_ready;
    ownerNempty = q_nempty[owner_q];
    load        = (state_q == SERVE) && slotFree && ownerNempty;
    burstDone   = (int'(burstCnt_q) + 1 == MAX_BURST);
    // Rotation happens either on the last word of a burst or as soon as the
    // owner is found empty while the slot could have taken a word; the two
    // are exclusive because an empty owner never loads.
    rotate      = (state_q == SERVE) &&
                  ((load && burstDone) || (slotFree && !ownerNempty));
    ownerOneHot          = '0;
    ownerOneHot[owner_q] = 1'b1;
    ownerPlus1  = IW'((int'(owner_q) + 1) % PORTS);
    q_se        = load ? ownerOneHot : '0;
  end

  // Shared round-robin search. In IDLE it starts at ptr; in SERVE it starts
  // just after the owner so the owner is the last candidate. When the owner
  // is rotating out because it ran empty, its stale flag is masked off.
  // Iterating downwards lets the nearest candidate overwrite farther ones.
  always_comb begin
    if (state_q == IDLE) begin
      srchStart = ptr_q;
      srchMask  = q_nempty;
    end else begin
      srchStart = ownerPlus1;
      srchMask  = load ? q_nempty : (q_nempty & ~ownerOneHot);
    end
    srchFound = 1'b0;
    srchIdx   = '0;
    candIdx   = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      candIdx = IW'((int'(srchStart) + k) % PORTS);
      if (srchMask[candIdx]) begin
        srchFound = 1'b1;
        srchIdx   = candIdx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    burstCnt_d = burstCnt_q;
    if (state_q == IDLE) begin
      if (srchFound) begin
        owner_d    = srchIdx;
        burstCnt_d = '0;
        state_d    = SERVE;
      end
    end else begin
      if (rotate) begin
        if (srchFound) begin
          owner_d    = srchIdx;
          burstCnt_d = '0;
        end else begin
          // Nobody else is waiting: remember where to resume next time.
          state_d = IDLE;
          ptr_d   = ownerPlus1;
        end
      end else if (load) begin
        burstCnt_d = burstCnt_q + 8'd1;
      end
    end
  end

  // Pop and capture happen on the same edge; a stalled word simply holds.
  always_comb begin
    oData_d  = oData_q;
    oSrc_d   = oSrc_q;
    oValid_d = oValid_q;
    if (load) begin
      oData_d  = q_dout[owner_q];
      oSrc_d   = owner_q;
      oValid_d = 1'b1;
    end else if (oValid_q && o_ready) begin
      oValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      burstCnt_q <= '0;
      oData_q    <= '0;
      oSrc_q     <= '0;
      oValid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      burstCnt_q <= burstCnt_d;
      oData_q    <= oData_d;
      oSrc_q     <= oSrc_d;
      oValid_q   <= oValid_d;
    end
  end

  assign o_data  = oData_q;
  assign o_src   = oSrc_q;
  assign o_valid = oValid_q;

endmodule

// File: tb/tb_queue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_queue_arbiter
//   Directed bench for queue_arbiter (WIDTH=32, PORTS=4, MAX_BURST=4).
//   Four small upstream queue models supply numbered words; each cycle the
//   bench drives o_ready and optional queue loads on the falling edge and
//   compares q_se, o_valid, o_src and o_data against hand-computed values.
// ---------------------------------------------------------------------------
module tb_queue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        oReady;
  logic [31:0] qDout [4];
  logic [3:0]  qNempty;
  logic [3:0]  qSe;
  logic [31:0] oData;
  logic [1:0]  oSrc;
  logic        oValid;

  int qCount [4] = '{0, 0, 0, 0};
  int qHead  [4] = '{0, 0, 0, 0};
  int setCnt [4] = '{0, 0, 0, 0};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rdy;
    logic [3:0]  ldMask;
    int          ldCnt;
    logic [3:0]  expSe;
    logic        expValid;
    logic [1:0]  expSrc;
    logic [31:0] expData;
    bit          chkData;
  } vec_t;

  vec_t vecs [16];

  queue_arbiter #(
    .WIDTH(32),
    .PORTS(4),
    .MAX_BURST(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .q_dout  (qDout),
    .q_nempty(qNempty),
    .q_se    (qSe),
    .o_data  (oData),
    .o_src   (oSrc),
    .o_valid (oValid),
    .o_ready (oReady)
  );

  always #5 clk = ~clk;

  // Word i of port p carries its origin so misrouted or repeated words show.
  function automatic logic [31:0] word(input int p, input int i);
    return 32'hC0DE_0000 | 32'(p * 256) | 32'(i);
  endfunction

  // Upstream queue models: head word and not-empty flag per port.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      qNempty[p] = (qCount[p] != 0);
      qDout[p]   = (qCount[p] != 0) ? word(p, qHead[p]) : 32'hDEAD_0000;
    end
  end

  // A load request refills an empty queue from word 0; otherwise pop on q_se.
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (setCnt[p] != 0) begin
        qCount[p] <= setCnt[p];
        qHead[p]  <= 0;
      end else if (qSe[p]) begin
        qCount[p] <= qCount[p] - 1;
        qHead[p]  <= qHead[p] + 1;
      end
    end
  end

  task automatic applyStimulus(input logic rdy, input logic [3:0] ldMask,
                               input int ldCnt);
    oReady = rdy;
    for (int p = 0; p < 4; p++) setCnt[p] = ldMask[p] ? ldCnt : 0;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expSe,
                             input logic expValid, input logic [1:0] expSrc,
                             input logic [31:0] expData, input bit chkData);
    checkValue({name, ".q_se"}, 32'(qSe), 32'(expSe));
    checkValue({name, ".se_on_empty"}, 32'(qSe & ~qNempty), 32'd0);
    checkValue({name, ".o_valid"}, 32'(oValid), 32'(expValid));
    if (chkData) begin
      checkValue({name, ".o_src"}, 32'(oSrc), 32'(expSrc));
      checkValue({name, ".o_data"}, oData, expData);
    end
  endtask

  task automatic cycleCheck(input string name, input logic rdy,
                            input logic [3:0] ldMask, input int ldCnt,
                            input logic [3:0] expSe, input logic expValid,
                            input logic [1:0] expSrc, input logic [31:0] expData,
                            input bit chkData);
    @(negedge clk);
    applyStimulus(rdy, ldMask, ldCnt);
    #1;
    checkOutput(name, expSe, expValid, expSrc, expData, chkData);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] seExp;
    int         src, idx, nsrc;

    // Port 2 holds 6 words, then ports 0 and 3 one word each (ptr resumes at 3).
    vecs[0]  = '{1'b1, 4'b0100, 6, 4'b0000, 1'b0, 2'd0, 32'h0,       1'b1};
    vecs[1]  = '{1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, 32'h0,       1'b1};
    vecs[2]  = '{1'b1, 4'b0000, 0, 4'b0100, 1'b0, 2'd0, 32'h0,       1'b1};
    vecs[3]  = '{1'b1, 4'b0000, 0, 4'b0100, 1'b1, 2'd2, word(2, 0),  1'b1};
    vecs[4]  = '{1'b1, 4'b0000, 0, 4'b0100, 1'b1, 2'd2, word(2, 1),  1'b1};
    vecs[5]  = '{1'b1, 4'b0000, 0, 4'b0100, 1'b1, 2'd2, word(2, 2),  1'b1};
    vecs[6]  = '{1'b1, 4'b0000, 0, 4'b0100, 1'b1, 2'd2, word(2, 3),  1'b1};
    vecs[7]  = '{1'b1, 4'b0000, 0, 4'b0100, 1'b1, 2'd2, word(2, 4),  1'b1};
    vecs[8]  = '{1'b1, 4'b0000, 0, 4'b0000, 1'b1, 2'd2, word(2, 5),  1'b1};
    vecs[9]  = '{1'b1, 4'b1001, 1, 4'b0000, 1'b0, 2'd2, word(2, 5),  1'b1};
    vecs[10] = '{1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd2, word(2, 5),  1'b1};
    vecs[11] = '{1'b1, 4'b0000, 0, 4'b1000, 1'b0, 2'd2, word(2, 5),  1'b1};
    vecs[12] = '{1'b1, 4'b0000, 0, 4'b0000, 1'b1, 2'd3, word(3, 0),  1'b1};
    vecs[13] = '{1'b1, 4'b0000, 0, 4'b0001, 1'b0, 2'd3, word(3, 0),  1'b1};
    vecs[14] = '{1'b1, 4'b0000, 0, 4'b0000, 1'b1, 2'd0, word(0, 0),  1'b1};
    vecs[15] = '{1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, word(0, 0),  1'b1};

    rst = 1'b1;
    applyStimulus(1'b0, 4'b0000, 0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 16; v++) begin
      cycleCheck($sformatf("vec%0d", v), vecs[v].rdy, vecs[v].ldMask,
                 vecs[v].ldCnt, vecs[v].expSe, vecs[v].expValid,
                 vecs[v].expSrc, vecs[v].expData, vecs[v].chkData);
    end

    // Reset between scenarios clears the held word and restarts at port 0.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0000, 0);
    #1;
    checkOutput("rst_between", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Ports 0 and 1 with 8 words each: alternating bursts of 4, no bubble.
    cycleCheck("b0", 1'b1, 4'b0011, 8, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("b1", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("b2", 1'b1, 4'b0000, 0, 4'b0001, 1'b0, 2'd0, 32'h0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      src   = (k / 4) % 2;
      idx   = (k / 8) * 4 + (k % 4);
      nsrc  = ((k + 1) / 4) % 2;
      seExp = (k < 15) ? 4'(1 << nsrc) : 4'b0000;
      cycleCheck($sformatf("b_word%0d", k), 1'b1, 4'b0000, 0, seExp, 1'b1,
                 2'(src), word(src, idx), 1'b1);
    end
    cycleCheck("b_end", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd1, word(1, 7), 1'b1);

    // Port 0 with 3 words, output stalled for 5 cycles after the first word.
    cycleCheck("d0", 1'b1, 4'b0001, 3, 4'b0000, 1'b0, 2'd1, word(1, 7), 1'b1);
    cycleCheck("d1", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd1, word(1, 7), 1'b1);
    cycleCheck("d2", 1'b1, 4'b0000, 0, 4'b0001, 1'b0, 2'd1, word(1, 7), 1'b1);
    for (int s = 0; s < 5; s++) begin
      cycleCheck($sformatf("d_stall%0d", s), 1'b0, 4'b0000, 0, 4'b0000, 1'b1,
                 2'd0, word(0, 0), 1'b1);
    end
    cycleCheck("d8",  1'b1, 4'b0000, 0, 4'b0001, 1'b1, 2'd0, word(0, 0), 1'b1);
    cycleCheck("d9",  1'b1, 4'b0000, 0, 4'b0001, 1'b1, 2'd0, word(0, 1), 1'b1);
    cycleCheck("d10", 1'b1, 4'b0000, 0, 4'b0000, 1'b1, 2'd0, word(0, 2), 1'b1);
    cycleCheck("d11", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, word(0, 2), 1'b1);

    // Port 1 runs dry after 2 words while port 0 waits: early rotation.
    cycleCheck("e0", 1'b1, 4'b0010, 2, 4'b0000, 1'b0, 2'd0, word(0, 2), 1'b1);
    cycleCheck("e1", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, word(0, 2), 1'b1);
    cycleCheck("e2", 1'b1, 4'b0001, 3, 4'b0010, 1'b0, 2'd0, word(0, 2), 1'b1);
    cycleCheck("e3", 1'b1, 4'b0000, 0, 4'b0010, 1'b1, 2'd1, word(1, 0), 1'b1);
    cycleCheck("e4", 1'b1, 4'b0000, 0, 4'b0000, 1'b1, 2'd1, word(1, 1), 1'b1);
    cycleCheck("e5", 1'b1, 4'b0000, 0, 4'b0001, 1'b0, 2'd1, word(1, 1), 1'b1);
    cycleCheck("e6", 1'b1, 4'b0000, 0, 4'b0001, 1'b1, 2'd0, word(0, 0), 1'b1);
    cycleCheck("e7", 1'b1, 4'b0000, 0, 4'b0001, 1'b1, 2'd0, word(0, 1), 1'b1);
    cycleCheck("e8", 1'b1, 4'b0000, 0, 4'b0000, 1'b1, 2'd0, word(0, 2), 1'b1);
    cycleCheck("e9", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, word(0, 2), 1'b1);

    // Reset mid-burst on port 1, then ports 1 and 2 compete from ptr 0.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 4'b0000, 0);
    @(negedge clk);
    rst = 1'b0;
    cycleCheck("f0", 1'b1, 4'b0010, 4, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("f1", 1'b1, 4'b0000, 0, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("f2", 1'b1, 4'b0000, 0, 4'b0010, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("f3", 1'b1, 4'b0000, 0, 4'b0010, 1'b1, 2'd1, word(1, 0), 1'b1);
    cycleCheck("f4", 1'b1, 4'b0000, 0, 4'b0010, 1'b1, 2'd1, word(1, 1), 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("f_rst_async", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("g0", 1'b1, 4'b0100, 2, 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 4'b0000, 0);
    #1;
    checkOutput("g1", 4'b0000, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("g2", 1'b1, 4'b0000, 0, 4'b0010, 1'b0, 2'd0, 32'h0, 1'b1);
    cycleCheck("g3", 1'b1, 4'b0000, 0, 4'b0010, 1'b1, 2'd1, word(1, 2), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
